serrcv: RTL
===========

# serrcv

Serial receive engine for the serial line interface. It synchronises the asynchronous `rxd` pin and detects start bits. It samples 8N1 frames at mid-bit using a programmable bit length, and delivers each received byte with a one-cycle strobe to the downstream receive buffer that feeds the bus-side data register. The bit length is the same 16-bit `bit_len` the interface derives from its baud-rate control write.

## Interface
- `SYNC_STAGES`, default 2: input synchroniser depth, minimum 2.
- `clk  in  1`: system clock (50 MHz nominal).
- `rst  in  1`: reset, asynchronous, active-low.
- `bit_len  in  16`: clocks per bit. Valid range is 8..65535. Behaviour for smaller values is undefined.
- `rxd  in  1`: serial input, idle high, asynchronous to `clk`.
- `strb  out  1`: one-cycle pulse; frame complete, `data`/`ferr`/`brk` valid.
- `data  out  8`: received byte, LSB first on the line. Held until the next `strb`.
- `ferr  out  1`: framing error (stop bit sampled 0). Updated with `strb` and held.
- `brk  out  1`: break (data == 0x00 and stop bit == 0). Updated with `strb` and held.
- `busy  out  1`: high whenever the state is not IDLE.

## Operation
- Synchroniser: `SYNC_STAGES` flops reset to 1, giving `rxs`. `rxp` is the previous value of `rxs`, also reset to 1.
- Start edge is `rxp==1 && rxs==0` in IDLE only. A low level without a preceding high never starts a frame, so a stuck-low line yields exactly one frame.
- `len_q` latches `bit_len` on the start edge. Changes to `bit_len` mid-frame have no effect until the next frame.
- 16-bit down-counter `cnt`. The sample point is `cnt==0`.
- States:
  - IDLE: on start edge, load `cnt = (bit_len>>1) - 1` and go to START.
  - START: at `cnt==0`, sample `rxs`. If 0, load `cnt = len_q-1`, set `bitn=0` and go to DATA. If 1 (glitch), go to IDLE with no strobe.
  - DATA: at `cnt==0`, shift `rxs` into the MSB of `shreg` (right shift) and reload `cnt = len_q-1`. When `bitn==7`, go to STOP; otherwise increment `bitn` (3 bits).
  - STOP: at `cnt==0`, set `data<=shreg`, `ferr<=~rxs`, `brk<=~rxs & (shreg==0)`, pulse `strb`, and go to IDLE.
- All counter arithmetic is 16-bit unsigned. `bit_len>>1` truncates.
- The cycle after `strb`, IDLE accepts a new start edge. Back-to-back frames are therefore supported, provided the stop bit was high.
- After a framing error, a new frame requires the line to return high, then fall.
- No overrun detection here; that belongs to the downstream buffer.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `strb=0`, `data=0x00`, `ferr=0`, `brk=0`, `busy=0`, `cnt=0`, `shreg=0`, synchroniser flops = 1.
- Reset asserted mid-frame aborts immediately: no `strb`, outputs return to reset values.
- `busy` rises the cycle after the start edge is seen on `rxs`.
- Define E as the first cycle `rxs==0`:
  - start sample at E + (bit_len>>1);
  - data bit k sample at E + (bit_len>>1) + (k+1)·bit_len;
  - `strb` high exactly one cycle at E + (bit_len>>1) + 9·bit_len.
  - `busy` falls the cycle after `strb`.
- From the pin to `rxs`: `SYNC_STAGES` cycles.
- `data`/`ferr`/`brk` change only in the `strb` cycle and are registered outputs.

## Structure
- Shared package `ser_pkg`:
  - state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - `SER_BIT_LEN_DFLT = 16'd5208`;
  - `SER_BIT_LEN_MIN = 16'd8`.
- One sub-module, `sync2`: a parameterised-depth bit synchroniser with reset value 1, reusable by the transmit side for CTS-style inputs.
- The remainder (FSM, counter, shift register, output registers) is flat in `serrcv`.

## Test plan
- bit_len=16, send 0x55 8N1 → one `strb` at E+8+144 cycles; `data=0x55`, `ferr=0`, `brk=0`.
- bit_len=16, low pulse of 5 cycles on `rxd` → no `strb`; `busy` high for 8 cycles, then IDLE. The next valid frame 0xA3 is received correctly.
- bit_len=16, frame 0x3C with stop bit 0 → `strb`, `data=0x3C`, `ferr=1`, `brk=0`. A following 0x81 after the line returns high gives `ferr=0`.
- bit_len=16, line held low for 20 bit times → exactly one `strb` with `data=0x00`, `ferr=1`, `brk=1`. No further strobe until the line goes high and falls again.
- bit_len=16, frames 0x01 then 0xFE back-to-back (no idle gap) → two strobes 160 cycles apart with the correct data. Changing `bit_len` to 32 during the first frame does not alter its sample points; the second frame uses 32.
- Assert `rst` low during data bit 4 → outputs are at reset values immediately and no `strb` occurs. After release, a fresh 0x7E frame is received correctly.

Source files
------------

// File: rtl/ser_pkg.sv
// ============================================================================
// Module   : ser_pkg
// Brief    : Shared encodings and constants for the serial line interface.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ser_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t START = 2'd1;
  localparam state_t DATA  = 2'd2;
  localparam state_t STOP  = 2'd3;

  localparam logic [15:0] SER_BIT_LEN_DFLT = 16'd5208;
  localparam logic [15:0] SER_BIT_LEN_MIN  = 16'd8;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
// Module   : sync2
// Brief    : Parameterised-depth single-bit synchroniser, resets to 1 (idle).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync2 #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/serrcv.sv
// ============================================================================
// Module   : serrcv
// Brief    : 8N1 serial receiver, mid-bit sampling with programmable bit length.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serrcv
  import ser_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bit_len,
  input  logic        rxd,
  output logic        strb,
  output logic [7:0]  data,
  output logic        ferr,
  output logic        brk,
  output logic        busy
);

  logic        w_rxs;
  logic        r_rxp;
  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [15:0] r_len;
  logic [2:0]  r_bitn;
  logic [7:0]  r_shreg;
  logic [7:0]  r_data;
  logic        r_ferr;
  logic        r_brk;
  logic        w_start_edge;
  logic        w_cnt_zero;

  sync2 #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (w_rxs)
  );

  // Only a falling edge starts a frame, so a line stuck low cannot retrigger.
  assign w_start_edge = (r_state == IDLE) && r_rxp && !w_rxs;
  assign w_cnt_zero   = (r_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_edge) w_next = START;
      START:   if (w_cnt_zero) w_next = w_rxs ? IDLE : DATA;
      DATA:    if (w_cnt_zero && (r_bitn == 3'd7)) w_next = STOP;
      STOP:    if (w_cnt_zero) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    strb = (r_state == STOP) && w_cnt_zero;
    busy = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rxp   <= 1'b1;
      r_cnt   <= 16'd0;
      r_len   <= 16'd0;
      r_bitn  <= 3'd0;
      r_shreg <= 8'h00;
      r_data  <= 8'h00;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
    end else begin
      r_rxp <= w_rxs;
      case (r_state)
        IDLE: begin
          if (w_start_edge) begin
            r_len <= bit_len;
            r_cnt <= (bit_len >> 1) - 16'd1;
          end
        end
        START: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (!w_rxs) begin
            r_cnt  <= r_len - 16'd1;
            r_bitn <= 3'd0;
          end
        end
        DATA: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 16'd1;
          end else begin
            r_shreg <= {w_rxs, r_shreg[7:1]};
            r_cnt   <= r_len - 16'd1;
            if (r_bitn != 3'd7) r_bitn <= r_bitn + 3'd1;
          end
        end
        STOP: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 16'd1;
          end else begin
            r_data <= r_shreg;
            r_ferr <= ~w_rxs;
            r_brk  <= ~w_rxs & (r_shreg == 8'h00);
          end
        end
        default: r_cnt <= 16'd0;
      endcase
    end
  end

  assign data = r_data;
  assign ferr = r_ferr;
  assign brk  = r_brk;

endmodule

`default_nettype wire
